// File: rtl/led_pattern_seq_if.sv
// Board-facing signal bundle for the LED pattern sequencer: the raw mode
// button coming in and the LED drive / current mode going out.
interface led_pattern_seq_if #(
    parameter int LED_NUM = 6
);
    logic               btn_n;
    logic [LED_NUM-1:0] leds;
    logic [1:0]         mode;

    modport master (output btn_n, input leds, input mode);
    modport slave  (input btn_n, output leds, output mode);
endinterface

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: debounced mode button cycles through four
// display patterns (blink, scan, binary count, PWM breathe) stepped at
// STEP_HZ. LEDs are active-low.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_BLINK   | all LEDs toggle every 4 step ticks
// ST_SCAN    | single lit LED bounces end to end, one bit per tick
// ST_COUNT   | LEDs show a binary counter incremented per tick
// ST_BREATHE | all LEDs PWM-dimmed, duty ramps 0..240..0 by 16 per tick
module led_pattern_seq #(
    parameter int CLOCK_XTAL   = 27000000,
    parameter int LED_NUM      = 6,
    parameter int STEP_HZ      = 8,
    parameter int DEBOUNCE_CYC = 540000
) (
    input  logic             clk,
    input  logic             rst,
    led_pattern_seq_if.slave bus
);

    localparam int STEP_DIV = CLOCK_XTAL / STEP_HZ;
    localparam int STEP_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DEB_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [LED_NUM-1:0] POS_FIRST = {{(LED_NUM-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_BLINK   = 2'd0,
        ST_SCAN    = 2'd1,
        ST_COUNT   = 2'd2,
        ST_BREATHE = 2'd3
    } state_t;

    state_t             state_q;
    logic               btn_s1_q, btn_s2_q, btn_acc_q;
    logic               armed_q;
    logic [1:0]         fill_q;
    logic [DEB_W-1:0]   deb_cnt_q;
    logic               press, tick;

    logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
    logic [1:0]         phase_q, phase_d;
    logic [LED_NUM-1:0] pos_q, pos_d;
    logic               dir_down_q, dir_down_d;
    logic [LED_NUM-1:0] count_q, count_d;
    logic [7:0]         duty_q, duty_d;
    logic               duty_down_q, duty_down_d;
    logic [7:0]         pwm_q;
    logic [LED_NUM-1:0] pattern_q, pattern_d;
    logic [LED_NUM-1:0] leds_q;

    // Button synchronizer and debouncer. armed_q only sets once the
    // synchronizer holds real samples showing the button released, so a
    // press held across reset cannot produce an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q  <= 1'b1;
            btn_s2_q  <= 1'b1;
            btn_acc_q <= 1'b1;
            deb_cnt_q <= '0;
            fill_q    <= 2'd0;
            armed_q   <= 1'b0;
        end else begin
            btn_s1_q <= bus.btn_n;
            btn_s2_q <= btn_s1_q;
            if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
            if (fill_q == 2'd2 && btn_s2_q) armed_q <= 1'b1;
            if (btn_s2_q == btn_acc_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                btn_acc_q <= btn_s2_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end
    end

    assign press = armed_q && btn_acc_q && !btn_s2_q && (deb_cnt_q == DEB_LAST);
    assign tick  = (step_cnt_q == STEP_LAST);

    // Mode FSM: one step around the ring per accepted press
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BLINK;
        end else if (press) begin
            case (state_q)
                ST_BLINK:   state_q <= ST_SCAN;
                ST_SCAN:    state_q <= ST_COUNT;
                ST_COUNT:   state_q <= ST_BREATHE;
                default:    state_q <= ST_BLINK;
            endcase
        end
    end

    // Pattern next-state; a press restarts every pattern generator and
    // swallows a coincident tick
    always_comb begin
        step_cnt_d  = tick ? '0 : step_cnt_q + 1'b1;
        phase_d     = phase_q;
        pos_d       = pos_q;
        dir_down_d  = dir_down_q;
        count_d     = count_q;
        duty_d      = duty_q;
        duty_down_d = duty_down_q;
        pattern_d   = pattern_q;
        if (press) begin
            step_cnt_d  = '0;
            phase_d     = 2'd0;
            pos_d       = POS_FIRST;
            dir_down_d  = 1'b0;
            count_d     = '0;
            duty_d      = 8'd0;
            duty_down_d = 1'b0;
            pattern_d   = (state_q == ST_BLINK) ? POS_FIRST : '0;
        end else begin
            case (state_q)
                ST_BLINK: begin
                    if (tick) begin
                        phase_d = phase_q + 2'd1;
                        if (phase_q == 2'd3) pattern_d = ~pattern_q;
                    end
                end
                ST_SCAN: begin
                    if (tick) begin
                        if (!dir_down_q) begin
                            pos_d = pos_q << 1;
                            if (pos_d[LED_NUM-1]) dir_down_d = 1'b1;
                        end else begin
                            pos_d = pos_q >> 1;
                            if (pos_d[0]) dir_down_d = 1'b0;
                        end
                        pattern_d = pos_d;
                    end
                end
                ST_COUNT: begin
                    if (tick) begin
                        count_d   = count_q + 1'b1;
                        pattern_d = count_d;
                    end
                end
                default: begin
                    if (tick) begin
                        if (!duty_down_q) begin
                            duty_d = duty_q + 8'd16;
                            if (duty_d == 8'd240) duty_down_d = 1'b1;
                        end else begin
                            duty_d = duty_q - 8'd16;
                            if (duty_d == 8'd0) duty_down_d = 1'b0;
                        end
                    end
                    pattern_d = (pwm_q < duty_d) ? '1 : '0;
                end
            endcase
        end
    end

    // Pattern state, free-running PWM and the active-low output register
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_q  <= '0;
            phase_q     <= 2'd0;
            pos_q       <= POS_FIRST;
            dir_down_q  <= 1'b0;
            count_q     <= '0;
            duty_q      <= 8'd0;
            duty_down_q <= 1'b0;
            pwm_q       <= 8'd0;
            pattern_q   <= '0;
            leds_q      <= '1;
        end else begin
            step_cnt_q  <= step_cnt_d;
            phase_q     <= phase_d;
            pos_q       <= pos_d;
            dir_down_q  <= dir_down_d;
            count_q     <= count_d;
            duty_q      <= duty_d;
            duty_down_q <= duty_down_d;
            pwm_q       <= pwm_q + 8'd1;
            pattern_q   <= pattern_d;
            leds_q      <= ~pattern_q;
        end
    end

    assign bus.leds = leds_q;
    assign bus.mode = state_q;

endmodule
